// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester and a
// data load/store requester. Data normally wins arbitration; a fetch that has lost
// MAX_WAIT consecutive arbitrations is forced to win the next one.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata  fetch grant, one-cycle response pulse, fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata     data grant, one-cycle response pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata  shared memory port
//   busy                       an access is in flight
module mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIfAcc, StDAcc} state_e;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_e        state_q;
    logic [3:0]    starve_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic idle;
    logic starved;

    assign idle    = (state_q == StIdle);
    assign starved = (starve_q == MaxWait);

    // A starved fetch overrides data priority; otherwise data wins any tie.
    assign if_gnt = idle & if_req & (starved | ~d_req);
    assign d_gnt  = idle & d_req & ~(starved & if_req);
    assign busy   = ~idle;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            // Response strobes are single-cycle pulses.
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_gnt) begin
                        state_q    <= StIfAcc;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        starve_q   <= 4'd0;
                    end else if (d_gnt) begin
                        state_q     <= StDAcc;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        // A waiting fetch just lost another arbitration.
                        if (!if_req) begin
                            starve_q <= 4'd0;
                        end else if (starve_q < MaxWait) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (!if_req) begin
                        starve_q <= 4'd0;
                    end
                end
                StIfAcc: begin
                    if (mem_ready) begin
                        state_q     <= StIdle;
                        mem_req_q   <= 1'b0;
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                end
                StDAcc: begin
                    if (mem_ready) begin
                        state_q    <= StIdle;
                        mem_req_q  <= 1'b0;
                        d_rvalid_q <= 1'b1;
                        // Stores complete without touching the load data register.
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
